// File: rtl/tick_scheduler_pkg.sv
// Shared types and default widths for the tick scheduler slice.
package tick_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_FREQ_IN = 10_000_000;
  localparam int DEF_N_REQ   = 2;
  localparam int DEF_DIV_W   = 16;
  localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/tick_scheduler_if.sv
// Requester bus of the tick scheduler: job handshake, abort, tick and completion outputs.
interface tick_scheduler_if
  import tick_scheduler_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ID_W  = $clog2(N_REQ)
) ();

  // Handshake: requester r holds i_req_valid[r] (with stable div/count) until it
  // sees o_req_ready[r] high in the same cycle; that cycle is the accept.
  logic [N_REQ-1:0]       i_req_valid;
  logic [N_REQ*DIV_W-1:0] i_req_div;
  logic [N_REQ*CNT_W-1:0] i_req_count;
  logic [N_REQ-1:0]       o_req_ready;
  logic                   i_abort;
  logic                   o_tick;
  logic                   o_busy;
  logic [ID_W-1:0]        o_owner;
  logic                   o_done;
  logic [ID_W-1:0]        o_done_id;
  logic                   o_aborted;
  state_t                 dbg_state;

  modport master (
    output i_req_valid, i_req_div, i_req_count, i_abort,
    input  o_req_ready, o_tick, o_busy, o_owner, o_done, o_done_id, o_aborted, dbg_state
  );

  modport slave (
    input  i_req_valid, i_req_div, i_req_count, i_abort,
    output o_req_ready, o_tick, o_busy, o_owner, o_done, o_done_id, o_aborted, dbg_state
  );

endinterface

// File: rtl/tick_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request at or after the pointer.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_id_o
);

  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ID_W'((int'(ptr_i) + i) % N_REQ);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Shared rate generator: accepts one job (divisor, tick count) at a time, round-robin
// across requesters, and emits single-cycle enable ticks plus a tagged done pulse.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int FRECUENCY_IN = DEF_FREQ_IN,
  parameter int N_REQ        = DEF_N_REQ,
  parameter int DIV_W        = DEF_DIV_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int ID_W         = $clog2(N_REQ)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  tick_scheduler_if.slave sl
);

  if (FRECUENCY_IN <= 0 || N_REQ < 2) begin : g_param_check
    $error("tick_scheduler: FRECUENCY_IN must be positive and N_REQ >= 2");
  end

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             aborted_q, aborted_d;

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic [DIV_W-1:0] req_div [N_REQ];
  logic [CNT_W-1:0] req_cnt [N_REQ];
  logic [N_REQ-1:0] ready;
  logic             tick;
  logic             last_phase;
  logic             final_tick;

  for (genvar r = 0; r < N_REQ; r++) begin : g_unpack
    assign req_div[r] = sl.i_req_div[r*DIV_W +: DIV_W];
    assign req_cnt[r] = sl.i_req_count[r*CNT_W +: CNT_W];
  end

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req_i    (sl.i_req_valid),
    .ptr_i    (rr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  // Ready is held low while reset is asserted so nothing looks accepted during reset.
  assign ready = (state_q == IDLE && i_rst) ? gnt : '0;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    div_d      = div_q;
    phase_d    = phase_q;
    rem_d      = rem_q;
    aborted_d  = aborted_q;
    tick       = 1'b0;
    last_phase = (phase_q == div_q - DIV_W'(1));
    final_tick = last_phase && (rem_q == CNT_W'(1));
    case (state_q)
      IDLE: begin
        if (|ready) begin
          owner_d   = gnt_id;
          div_d     = (req_div[gnt_id] == '0) ? DIV_W'(1) : req_div[gnt_id];
          rem_d     = req_cnt[gnt_id];
          phase_d   = '0;
          aborted_d = 1'b0;
          state_d   = (req_cnt[gnt_id] == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // An abort only suppresses a tick that is not the job's last one.
        if (last_phase && (!sl.i_abort || final_tick)) begin
          tick    = 1'b1;
          phase_d = '0;
          rem_d   = rem_q - CNT_W'(1);
          if (final_tick) state_d = DONE;
        end else if (sl.i_abort) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else begin
          phase_d = phase_q + DIV_W'(1);
        end
      end
      DONE: begin
        rr_d    = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      div_q     <= '0;
      phase_q   <= '0;
      rem_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      rem_q     <= rem_d;
      aborted_q <= aborted_d;
    end
  end

  assign sl.o_req_ready = ready;
  assign sl.o_tick      = tick;
  assign sl.o_busy      = (state_q != IDLE);
  assign sl.o_owner     = owner_q;
  assign sl.o_done      = (state_q == DONE);
  assign sl.o_done_id   = (state_q == DONE) ? owner_q : '0;
  assign sl.o_aborted   = (state_q == DONE) && aborted_q;
  assign sl.dbg_state   = state_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: job table plus reset and arbitration sequences, tick/done scoreboard.
module tb_tick_scheduler;
  import tick_scheduler_pkg::*;

  localparam int N_REQ = 2;
  localparam int DIV_W = 16;
  localparam int CNT_W = 8;
  localparam int ID_W  = 1;

  typedef struct {
    int id;
    int dv;
    int cn;
    int ab_rel;
    int exp_ticks;
    int exp_ab;
  } vec_t;

  logic clk;
  logic rst_n;
  int unsigned cyc = 0;
  int pass_cnt = 0;
  int chk_cnt = 0;
  int job_ticks = 0;
  int onehot_err = 0;
  logic [31:0] tick_q[$];
  logic [55:0] done_q[$];
  vec_t vecs[9];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tick_scheduler_if #(.N_REQ(N_REQ), .DIV_W(DIV_W), .CNT_W(CNT_W), .ID_W(ID_W)) sl ();

  tick_scheduler #(
    .FRECUENCY_IN(10_000_000), .N_REQ(N_REQ), .DIV_W(DIV_W), .CNT_W(CNT_W), .ID_W(ID_W)
  ) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .sl    (sl)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [31:0] exp_t;
    logic [55:0] d;
    if ($countones(sl.o_req_ready) > 1) onehot_err++;
    while (tick_q.size() > 0 && tick_q[0] < cyc) check("tick_missed", cyc, tick_q.pop_front());
    if (sl.o_tick === 1'b1) begin
      if (tick_q.size() > 0) exp_t = tick_q.pop_front();
      else exp_t = 32'hFFFF_FFFF;
      check("tick_time", cyc, exp_t);
      job_ticks++;
    end
    while (done_q.size() > 0 && done_q[0][31:0] < cyc) begin
      d = done_q.pop_front();
      check("done_missed", cyc, d[31:0]);
    end
    if (sl.o_done === 1'b1) begin
      if (done_q.size() > 0) d = done_q.pop_front();
      else d = '1;
      check("done_time", cyc, d[31:0]);
      check("done_id", 32'(sl.o_done_id), 32'(d[38:32]));
      check("done_aborted", 32'(sl.o_aborted), 32'(d[39]));
      check("job_ticks", 32'(job_ticks), 32'(d[55:40]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int id, input int dv, input int cn);
    sl.i_req_div[id*DIV_W +: DIV_W]   = DIV_W'(dv);
    sl.i_req_count[id*CNT_W +: CNT_W] = CNT_W'(cn);
    sl.i_req_valid[id]                = 1'b1;
  endtask

  // Reference model of one job, anchored at the accept cycle t.
  task automatic push_exp(input int id, input int dv, input int cn, input int ab_rel,
                          input int t, input int exp_ticks, input int exp_ab);
    int de, fin, a;
    bit ab;
    de  = (dv == 0) ? 1 : dv;
    fin = t + de * cn;
    a   = (ab_rel >= 0) ? t + de + ab_rel : -1;
    ab  = (cn > 0) && (ab_rel >= 0) && (a < fin);
    for (int j = 1; j <= cn; j++)
      if (!ab || (t + de * j) < a) tick_q.push_back(32'(t + de * j));
    done_q.push_back({16'(exp_ticks), 1'(exp_ab), 7'(id), 32'(ab ? a + 1 : fin + 1)});
    job_ticks = 0;
  endtask

  task automatic wait_accept(input int id, output int t);
    bit got;
    int gid;
    got = 1'b0;
    t   = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if ((sl.i_req_valid & sl.o_req_ready) != '0) begin
        got = 1'b1;
        t   = int'(cyc);
        gid = -1;
        for (int r = 0; r < N_REQ; r++)
          if (sl.o_req_ready[r] && sl.i_req_valid[r] && gid < 0) gid = r;
        check("accept_id", 32'(gid), 32'(id));
      end
    end
    check("accept_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_done(input int limit);
    bit got;
    got = 1'b0;
    for (int k = 0; k < limit && !got; k++) begin
      @(negedge clk);
      if (sl.o_done === 1'b1) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_row(input vec_t v);
    int t, a;
    @(posedge clk); #1;
    drive_req(v.id, v.dv, v.cn);
    wait_accept(v.id, t);
    push_exp(v.id, v.dv, v.cn, v.ab_rel, t, v.exp_ticks, v.exp_ab);
    @(posedge clk); #1;
    sl.i_req_valid[v.id] = 1'b0;
    if (v.ab_rel >= 0) begin
      a = t + ((v.dv == 0) ? 1 : v.dv) + v.ab_rel;
      while (int'(cyc) < a) begin @(posedge clk); #1; end
      sl.i_abort = 1'b1;
      @(posedge clk); #1;
      sl.i_abort = 1'b0;
    end
    wait_done(3000);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},   32'(sl.o_req_ready), 32'd0);
    check({tag, "_busy"},    32'(sl.o_busy),      32'd0);
    check({tag, "_tick"},    32'(sl.o_tick),      32'd0);
    check({tag, "_done"},    32'(sl.o_done),      32'd0);
    check({tag, "_owner"},   32'(sl.o_owner),     32'd0);
    check({tag, "_aborted"}, 32'(sl.o_aborted),   32'd0);
    check({tag, "_state"},   32'(sl.dbg_state),   32'(IDLE));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t, prev_t, rn;
    vecs[0] = '{0, 4, 3, -1, 3, 0};
    vecs[1] = '{1, 0, 2, -1, 2, 0};
    vecs[2] = '{0, 3, 0, -1, 0, 0};
    vecs[3] = '{1, 10, 5, 3, 1, 1};
    vecs[4] = '{0, 1, 3, -1, 3, 0};
    vecs[5] = '{1, 5, 2, 5, 2, 0};
    rn      = $urandom_range(0, 4);
    vecs[6] = '{0, $urandom_range(1, 6), rn, -1, rn, 0};
    vecs[7] = '{1, 3, 255, -1, 255, 0};
    vecs[8] = '{0, 1, 1, -1, 1, 0};

    rst_n          = 1'b0;
    sl.i_req_valid = '0;
    sl.i_req_div   = '0;
    sl.i_req_count = '0;
    sl.i_abort     = 1'b0;
    drive_req(0, 4, 3);
    drive_req(1, 4, 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    sl.i_req_valid = '0;
    rst_n          = 1'b1;

    foreach (vecs[i]) run_row(vecs[i]);

    // Reset in the middle of a running job from requester 1 (rr pointer is 1 here).
    drive_req(1, 10, 5);
    wait_accept(1, t);
    push_exp(1, 10, 5, -1, t, 5, 0);
    @(posedge clk); #1;
    sl.i_req_valid[1] = 1'b0;
    while (int'(cyc) < t + 15) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick_q.delete();
    done_q.delete();
    @(negedge clk);
    check_idle_outputs("midrun_reset");

    // Both requesters hold valid: grants alternate from 0 with one idle cycle after each DONE.
    @(posedge clk); #1;
    drive_req(0, 2, 1);
    drive_req(1, 2, 1);
    prev_t = 0;
    for (int n = 0; n < 4; n++) begin
      wait_accept(n % 2, t);
      push_exp(n % 2, 2, 1, -1, t, 1, 0);
      if (n > 0) check("accept_gap", 32'(t - prev_t), 32'd4);
      prev_t = t;
    end
    @(posedge clk); #1;
    sl.i_req_valid = '0;
    wait_done(20);
    repeat (3) @(posedge clk);
    @(negedge clk);

    check("onehot_violations", 32'(onehot_err), 32'd0);
    check("tick_q_left", 32'(tick_q.size()), 32'd0);
    check("done_q_left", 32'(done_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
